// File: rtl/cnn_pixel_streamer.sv
// Frame reader: fetches packed 32-bit words from memory one request at a time
// and streams them out as 8-bit pixels with sof/eol/eof framing.
module cnn_pixel_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [31:0]           base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic [31:0]           mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [DATA_WIDTH-1:0] pixel_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  eof_o
);

  localparam int NWORDS = WIDTH * HEIGHT / 4;
  localparam int WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DRAIN, S_DONE
  } state_t;

  state_t          r_state;
  logic [31:0]     r_addr;
  logic [WW-1:0]   r_word_idx;
  logic [31:0]     r_word;
  logic [1:0]      r_byte;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_busy;
  logic            r_done;
  logic            r_req;
  logic            r_valid;

  logic w_last_col;
  logic w_last_row;
  logic w_last_word;

  assign w_last_col  = (r_col == CW'(WIDTH - 1));
  assign w_last_row  = (r_row == RW'(HEIGHT - 1));
  assign w_last_word = (r_word_idx == WW'(NWORDS - 1));

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign mem_req_o  = r_req;
  assign mem_addr_o = r_addr;
  assign valid_o    = r_valid;
  // Framing derives only from registers, so it holds steady while stalled.
  assign pixel_o    = r_word[{r_byte, 3'b000} +: DATA_WIDTH];
  assign sof_o      = r_valid & (r_row == '0) & (r_col == '0);
  assign eol_o      = r_valid & w_last_col;
  assign eof_o      = r_valid & w_last_col & w_last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_word_idx <= '0;
      r_word     <= '0;
      r_byte     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state    <= S_REQ;
            r_busy     <= 1'b1;
            r_req      <= 1'b1;
            r_addr     <= base_addr_i & 32'hFFFF_FFFC;
            r_word_idx <= '0;
            r_col      <= '0;
            r_row      <= '0;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            // An accepted request always returns data, so abort must drain it.
            r_req   <= 1'b0;
            r_state <= abort_i ? S_DRAIN : S_WAIT;
          end else if (abort_i) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (abort_i) begin
            if (mem_rvalid_i) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (mem_rvalid_i) begin
            r_word  <= mem_rdata_i;
            r_byte  <= '0;
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (abort_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (ready_i) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (r_byte == 2'd3) begin
              r_valid <= 1'b0;
              if (w_last_word) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_word_idx <= r_word_idx + 1'b1;
                r_addr     <= r_addr + 32'd4;
                r_req      <= 1'b1;
                r_state    <= S_REQ;
              end
            end else begin
              r_byte <= r_byte + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (mem_rvalid_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Randomized bench: a memory responder plus a frame-level pixel model checked
// every negedge, with a few literal frame totals pinning the model.
module tb_cnn_pixel_streamer;
  localparam int W = 28, H = 28, NPIX = W * H;

  logic        clk = 0, rst_n = 0, start_i = 0, abort_i = 0;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0, ready_i = 0;
  logic [31:0] base_addr_i = 0, mem_rdata_i = 0;
  logic        busy_o, done_o, mem_req_o, valid_o, sof_o, eol_o, eof_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  pixel_o;

  cnn_pixel_streamer #(.DATA_WIDTH(8), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .pixel_o(pixel_o),
    .valid_o(valid_o), .ready_i(ready_i), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int gmin = 0, gmax = 0, rmin = 0, rmax = 0, rdy_pct = 100;
  logic [31:0] exp_base = 0, pend_addr = 0, first_addr = 0, last_addr = 0;
  int pix_n = 0, nreq = 0, gcnt = 0, rcnt = 0;
  int n_sof = 0, n_eol = 0, n_eof = 0, n_done = 0;
  bit outstanding = 0, dead = 1, exp_done = 0, exp_idle = 0, exp_req = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ (a >> 5) ^ 32'h5A5A_0F0F;
  endfunction

  // Pixel n of a frame is byte n%4 of the word at base + 4*(n/4).
  function automatic logic [7:0] exp_pix(input logic [31:0] base, input int n);
    logic [31:0] w;
    w = memf(base + 32'(4 * (n / 4)));
    return w[8 * (n % 4) +: 8];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs", {busy_o, done_o, mem_req_o, valid_o, sof_o, eol_o, eof_o, pixel_o, mem_addr_o}, 64'd0);
      mem_gnt_i = 0; mem_rvalid_i = 0; outstanding = 0; dead = 1;
      exp_done = 0; exp_idle = 0; exp_req = 0;
    end else begin
      chk("done", done_o, exp_done);
      if (exp_done) chk("done_busy", busy_o, 1);
      if (exp_idle) chk("to_idle", busy_o, 0);
      if (exp_req)  chk("req_latency", {busy_o, mem_req_o}, 2'b11);
      exp_idle = done_o; exp_done = 0; exp_req = 0;
      if (done_o) n_done++;

      if (mem_rvalid_i) begin
        mem_rvalid_i = 0; outstanding = 0;
        if (dead) chk("drain_exit", busy_o, 0);
        else      chk("valid_latency", valid_o, 1);
      end
      if (mem_gnt_i) begin
        mem_gnt_i = 0;
        chk("req_drop", mem_req_o, 0);
        outstanding = 1;
        rcnt = rmin + $urandom_range(rmax - rmin);
        gcnt = gmin + $urandom_range(gmax - gmin);
        if (nreq == 0) first_addr = pend_addr;
        last_addr = pend_addr;
        nreq++;
      end
      if (outstanding && rcnt == 0) begin
        mem_rvalid_i = 1; mem_rdata_i = memf(pend_addr);
      end else begin
        if (outstanding) rcnt--;
        mem_rdata_i = $urandom;
      end
      if (mem_req_o) begin
        chk("one_outstanding", outstanding, 0);
        chk("req_addr", mem_addr_o, exp_base + 32'(4 * nreq));
        chk("req_vs_valid", valid_o, 0);
        if (gcnt == 0) begin mem_gnt_i = 1; pend_addr = mem_addr_o; end
        else gcnt--;
      end

      if (dead) chk("dead_valid", valid_o, 0);
      else if (valid_o) begin
        chk("pixel", pixel_o, exp_pix(exp_base, pix_n));
        chk("flags", {sof_o, eol_o, eof_o}, {pix_n == 0, (pix_n % W) == W - 1, pix_n == NPIX - 1});
      end else chk("flags_idle", {sof_o, eol_o, eof_o}, 3'b000);

      ready_i = ($urandom_range(99) < rdy_pct);
      if (!dead && valid_o && ready_i && !abort_i) begin
        n_sof += int'(sof_o); n_eol += int'(eol_o); n_eof += int'(eof_o);
        if (pix_n == NPIX - 1) begin exp_done = 1; dead = 1; end
        pix_n++;
      end
      if (abort_i && busy_o && !dead) begin
        dead = 1;
        if (valid_o || (mem_req_o && !mem_gnt_i)) exp_idle = 1;
      end
      if (start_i && !busy_o) begin
        exp_base = base_addr_i & 32'hFFFF_FFFC;
        pix_n = 0; nreq = 0; dead = 0; exp_req = 1;
        n_sof = 0; n_eol = 0; n_eof = 0; n_done = 0;
        gcnt = gmin + $urandom_range(gmax - gmin);
      end
    end
  end

  task automatic do_start(input logic [31:0] base);
    @(posedge clk); #1; start_i = 1; base_addr_i = base;
    @(posedge clk); #1; start_i = 0;
  endtask

  task automatic pulse_abort();
    abort_i = 1; @(posedge clk); #1; abort_i = 0;
  endtask

  task automatic wait_pix(input int n, input int budget);
    int k = 0;
    while (pix_n < n && k < budget) begin @(posedge clk); #1; k++; end
    chk("wait_pix", pix_n >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(posedge clk); #1;
    while (busy_o && k < budget) begin @(posedge clk); #1; k++; end
    chk("wait_idle", busy_o, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1; rst_n = 1;

    // Full frame, single-cycle memory; start held through the end of frame and DONE.
    do_start(32'h1000);
    wait_pix(780, 5000);
    start_i = 1; base_addr_i = 32'h2000;
    k = 0;
    while (!done_o && k < 100) begin @(posedge clk); #1; k++; end
    chk("done_seen", done_o, 1);
    @(posedge clk); #1; start_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_in_done_ignored", busy_o, 0);
    chk("f1_words", nreq, 196);
    chk("f1_first_addr", first_addr, 32'h1000);
    chk("f1_last_addr", last_addr, 32'h130C);
    chk("f1_pixels", pix_n, 784);
    chk("f1_eol", n_eol, 28);
    chk("f1_sof_eof", {n_sof[7:0], n_eof[7:0]}, 16'h0101);
    chk("f1_done", n_done, 1);
    chk("f1_pix0", exp_pix(32'h1000, 0), 8'(memf(32'h1000)));

    // Backpressure and jittery memory.
    gmin = 0; gmax = 2; rmin = 0; rmax = 3; rdy_pct = 50;
    do_start(32'h0004_2A10);
    wait_idle(20000);
    chk("f2_pixels", pix_n, 784);
    chk("f2_done", n_done, 1);

    // Slow memory, unaligned base.
    gmin = 3; gmax = 3; rmin = 4; rmax = 4; rdy_pct = 100;
    do_start(32'h1003);
    wait_idle(8000);
    chk("f3_first_addr", first_addr, 32'h1000);
    chk("f3_last_addr", last_addr, 32'h130C);
    chk("f3_words", nreq, 196);

    // Abort while waiting for read data.
    gmin = 0; gmax = 0; rmin = 4; rmax = 4;
    do_start(32'h3000);
    k = 0;
    while (!outstanding && k < 50) begin @(posedge clk); #1; k++; end
    chk("abort_wait_reached", outstanding, 1);
    pulse_abort();
    wait_idle(50);
    chk("abort_wait_pixels", pix_n, 0);
    chk("abort_wait_done", n_done, 0);

    // Abort mid-emit.
    rmin = 0; rmax = 2; rdy_pct = 50;
    do_start(32'h3100);
    wait_pix(10, 500);
    pulse_abort();
    wait_idle(50);
    chk("abort_emit_done", n_done, 0);

    // Abort in REQ before grant, then abort while idle.
    gmin = 5; gmax = 5;
    do_start(32'h3200);
    pulse_abort();
    wait_idle(10);
    pulse_abort();
    @(posedge clk); #1;
    chk("abort_idle_noop", busy_o, 0);

    // Fresh frame after aborts starts again from pixel 0.
    gmin = 0; gmax = 1; rmin = 0; rmax = 1; rdy_pct = 70;
    do_start(32'h3000);
    wait_idle(10000);
    chk("f4_pixels", pix_n, 784);
    chk("f4_sof", n_sof, 1);
    chk("f4_done", n_done, 1);

    // Reset at pixel 100 abandons the frame at once.
    gmin = 0; gmax = 0; rmin = 0; rmax = 0; rdy_pct = 100;
    do_start(32'h5000);
    wait_pix(100, 2000);
    rst_n = 0;
    #1;
    chk("reset_immediate", {busy_o, done_o, mem_req_o, valid_o, sof_o, eol_o, eof_o, pixel_o, mem_addr_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", {busy_o, valid_o, mem_req_o}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end
endmodule
